// File: rtl/view_pan_pkg.sv
// view_pan_pkg: shared axis state, offset/direction types and sizing helpers
// for the view pan controller.
package view_pan_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} axis_state_e;
   typedef logic [10:0] offset_t;
   typedef logic signed [1:0] dir_t;
   localparam dir_t DIR_NONE = 2'sd0;
   localparam dir_t DIR_POS = 2'sd1;
   localparam dir_t DIR_NEG = -2'sd1;
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction
   // Signed 12-bit sum so a step below MIN or above MAX clamps instead of wrapping.
   function automatic offset_t clamp_step(input offset_t off, input dir_t dir, input int step,
                                          input int lo, input int hi);
      logic signed [11:0] s;
      s = (dir == DIR_NEG) ? $signed({1'b0, off}) - $signed(12'(step))
                           : $signed({1'b0, off}) + $signed(12'(step));
      return (s < $signed(12'(lo))) ? offset_t'(lo) : (s > $signed(12'(hi))) ? offset_t'(hi) : offset_t'(s);
   endfunction
endpackage

// File: rtl/view_pan_controller_axis.sv
// pan_axis: press / hold / auto-repeat FSM for one axis with a clamped offset register.
module pan_axis
   import view_pan_pkg::*;
#(
   parameter int REPEAT_DELAY = 32500000,
   parameter int REPEAT_RATE = 3250000,
   parameter int STEP = 1,
   parameter int INIT = 300,
   parameter int MIN = 0,
   parameter int MAX = 1023,
   parameter int CW = 25
)(
   input  logic    clk,
   input  logic    reset_n,
   input  logic    inc_i,
   input  logic    dec_i,
   input  logic    recenter_i,
   output offset_t off_o,
   output logic    chg_o
);
   axis_state_e state_q, state_d;
   dir_t dir, dir_q, dir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   offset_t off_q, off_d;
   logic chg_q, step;
   assign dir = (inc_i && !dec_i) ? DIR_POS : (dec_i && !inc_i) ? DIR_NEG : DIR_NONE;
   assign off_o = off_q;
   assign chg_o = chg_q;
   // HOLD and REPEAT differ only in which reload brought them there.
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      dir_d = dir_q;
      step = 1'b0;
      if (recenter_i) begin
         state_d = IDLE;
         cnt_d = '0;
      end else if (state_q == IDLE) begin
         if (dir != DIR_NONE) begin
            step = 1'b1;
            dir_d = dir;
            cnt_d = CW'(REPEAT_DELAY);
            state_d = HOLD;
         end
      end else if (dir == DIR_NONE) begin
         state_d = IDLE;
         cnt_d = '0;
      end else if (dir != dir_q) begin
         step = 1'b1;
         dir_d = dir;
         cnt_d = CW'(REPEAT_DELAY);
         state_d = HOLD;
      end else if (cnt_q == CW'(1)) begin
         step = 1'b1;
         cnt_d = CW'(REPEAT_RATE);
         state_d = REPEAT;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
      off_d = recenter_i ? offset_t'(INIT) : step ? clamp_step(off_q, dir, STEP, MIN, MAX) : off_q;
   end
   always_ff @(posedge clk)
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q <= '0;
         dir_q <= DIR_NONE;
         off_q <= offset_t'(INIT);
         chg_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         dir_q <= dir_d;
         off_q <= off_d;
         chg_q <= off_d != off_q;
      end
endmodule

// File: rtl/view_pan_controller_debouncer.sv
// button_debouncer: 2-flop synchroniser plus stable-count debouncer; a button held
// through reset must be seen released before its level can rise again.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 650000
)(
   input  logic clk,
   input  logic reset_n,
   input  logic raw_i,
   output logic level_o
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   logic s1_q, s2_q, arm_q, level_q, differ, done;
   logic [CW-1:0] cnt_q;
   assign differ = arm_q && (s2_q != level_q);
   assign done = differ && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
   assign level_o = level_q;
   // Synchroniser resets high so a still-held button keeps the arm flag clear.
   always_ff @(posedge clk)
      if (!reset_n) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
         arm_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q <= raw_i;
         s2_q <= s1_q;
         arm_q <= arm_q | ~s2_q;
         cnt_q <= (differ && !done) ? cnt_q + 1'b1 : '0;
         level_q <= done ? s2_q : level_q;
      end
endmodule

// File: rtl/view_pan_controller.sv
// view_pan_controller: debounced pushbuttons drive two independent auto-repeating,
// saturating view offset axes with a shared recenter.
module view_pan_controller
   import view_pan_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 650000,
   parameter int REPEAT_DELAY = 32500000,
   parameter int REPEAT_RATE = 3250000,
   parameter int STEP = 1,
   parameter int X_INIT = 300,
   parameter int Y_INIT = 300,
   parameter int X_MIN = 0,
   parameter int X_MAX = 1023,
   parameter int Y_MIN = 0,
   parameter int Y_MAX = 767
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        left,
   input  logic        right,
   input  logic        up,
   input  logic        down,
   input  logic        recenter,
   output logic [10:0] x_offset,
   output logic [10:0] y_offset,
   output logic        moving
);
   localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);
   logic [4:0] raw, lvl;
   logic rc_q, rc_rise, x_chg, y_chg;
   assign raw = {recenter, down, up, right, left};
   for (genvar g = 0; g < 5; g++) begin : g_db
      button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk(clk), .reset_n(reset_n), .raw_i(raw[g]), .level_o(lvl[g]));
   end
   assign rc_rise = lvl[4] && !rc_q;
   always_ff @(posedge clk)
      if (!reset_n) rc_q <= 1'b0;
      else rc_q <= lvl[4];
   pan_axis #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .STEP(STEP),
              .INIT(X_INIT), .MIN(X_MIN), .MAX(X_MAX), .CW(CW)) u_x (
      .clk(clk), .reset_n(reset_n), .inc_i(lvl[1]), .dec_i(lvl[0]), .recenter_i(rc_rise),
      .off_o(x_offset), .chg_o(x_chg));
   pan_axis #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE), .STEP(STEP),
              .INIT(Y_INIT), .MIN(Y_MIN), .MAX(Y_MAX), .CW(CW)) u_y (
      .clk(clk), .reset_n(reset_n), .inc_i(lvl[3]), .dec_i(lvl[2]), .recenter_i(rc_rise),
      .off_o(y_offset), .chg_o(y_chg));
   assign moving = x_chg | y_chg;
endmodule

// File: tb/tb_view_pan_controller.sv
// tb_view_pan_controller: scoreboard of expected offset changes (cycle, value) per axis,
// pushed when buttons are driven and popped when the DUT offsets move.
module tb_view_pan_controller;
   localparam int DLY = 10, RATE = 3, XMAX = 305, YMAX = 767;
   logic clk = 1'b0, reset_n = 1'b0;
   logic left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0, recenter = 1'b0;
   logic [10:0] x_offset, y_offset;
   logic moving;
   int cyc = 0, checks = 0, failures = 0, px = 0, py = 0, mx = 300, my = 300, p, r;
   typedef struct {int cyc; int val;} ev_t;
   ev_t xq[$], yq[$];
   ev_t ex, ey;

   view_pan_controller #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .X_MAX(XMAX)) dut (
      .clk(clk), .reset_n(reset_n), .left(left), .right(right), .up(up), .down(down),
      .recenter(recenter), .x_offset(x_offset), .y_offset(y_offset), .moving(moving));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         px = int'(x_offset);
         py = int'(y_offset);
      end else begin
         chk("moving", int'(moving), int'(int'(x_offset) != px || int'(y_offset) != py));
         if (int'(x_offset) != px) begin
            if (xq.size() == 0) chk("x_unexpected", int'(x_offset), px);
            else begin
               ex = xq.pop_front();
               chk("x_cycle", cyc, ex.cyc);
               chk("x_value", int'(x_offset), ex.val);
            end
         end
         if (int'(y_offset) != py) begin
            if (yq.size() == 0) chk("y_unexpected", int'(y_offset), py);
            else begin
               ey = yq.pop_front();
               chk("y_cycle", cyc, ey.cyc);
               chk("y_value", int'(y_offset), ey.val);
            end
         end
         px = int'(x_offset);
         py = int'(y_offset);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push(input bit ax, input int t, input int v);
      if (ax) yq.push_back('{cyc: t, val: v});
      else xq.push_back('{cyc: t, val: v});
   endtask

   // Steps at first, first+DLY, then every RATE, up to and including edge last.
   task automatic push_hold(input bit ax, input int first, input int last, input int dir, inout int v);
      int t, k, nv, hi;
      t = first;
      k = 0;
      hi = ax ? YMAX : XMAX;
      while (t <= last) begin
         nv = v + dir;
         nv = (nv < 0) ? 0 : (nv > hi) ? hi : nv;
         if (nv != v) begin
            v = nv;
            push(ax, t, v);
         end
         t += (k == 0) ? DLY : RATE;
         k++;
      end
   endtask

   task automatic settle(input int n);
      int k;
      k = 0;
      while ((xq.size() + yq.size()) != 0 && k < 300) begin
         @(posedge clk);
         k++;
      end
      repeat (n) @(posedge clk);
      #2;
      chk("drained", xq.size() + yq.size(), 0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      mx = 300;
      my = 300;
      chk("rst_x", int'(x_offset), 300);
      chk("rst_y", int'(y_offset), 300);
      chk("rst_moving", int'(moving), 0);
      tick(4);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      do_reset();
      // Held press: first step after sync+debounce+1, then delay, then repeat rate.
      p = cyc;
      push_hold(0, p + 7, p + 18 + 6, 1, mx);
      right = 1'b1;
      tick(18);
      right = 1'b0;
      settle(15);
      // Short glitch never reaches the debounced level.
      do_reset();
      right = 1'b1;
      tick(3);
      right = 1'b0;
      settle(15);
      chk("glitch_x", int'(x_offset), 300);
      // Opposite buttons cancel; releasing one leaves the other active.
      left = 1'b1;
      right = 1'b1;
      tick(50);
      r = cyc;
      push_hold(0, r + 7, r + 5 + 6, -1, mx);
      right = 1'b0;
      tick(5);
      left = 1'b0;
      settle(15);
      // Saturation at X_MAX.
      do_reset();
      p = cyc;
      push_hold(0, p + 7, p + 60 + 6, 1, mx);
      right = 1'b1;
      tick(60);
      right = 1'b0;
      settle(15);
      chk("sat_x", int'(x_offset), XMAX);
      // Recenter lands on a scheduled repeat step; held axes restart one cycle later.
      do_reset();
      p = cyc;
      push_hold(0, p + 7, p + 19, 1, mx);
      push_hold(1, p + 7, p + 19, -1, my);
      push(0, p + 20, 300);
      push(1, p + 20, 300);
      mx = 300;
      my = 300;
      push_hold(0, p + 21, p + 25 + 6, 1, mx);
      push_hold(1, p + 21, p + 25 + 6, -1, my);
      right = 1'b1;
      up = 1'b1;
      tick(13);
      recenter = 1'b1;
      tick(12);
      right = 1'b0;
      up = 1'b0;
      tick(5);
      recenter = 1'b0;
      settle(15);
      // Reset mid-repeat; a held button must be released and re-pressed.
      do_reset();
      p = cyc;
      push_hold(0, p + 7, p + 21, 1, mx);
      right = 1'b1;
      tick(21);
      do_reset();
      tick(30);
      right = 1'b0;
      tick(10);
      p = cyc;
      push_hold(0, p + 7, p + 5 + 6, 1, mx);
      right = 1'b1;
      tick(5);
      right = 1'b0;
      settle(15);
      chk("final_x", int'(x_offset), 301);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
